sme_host: RTL and testbench

//   Host-side driver for the string-match engine (SME) char interface. Walks a job list in a

---
 rtl/sme_host_if.sv | 28 ++
 rtl/sme_host.sv | 239 +++++++++++++++++++++++
 tb/tb_sme_host.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sme_host_if.sv
// Character interface between the SME host driver and the string-match engine.
// The host drives characters and strobes; the engine answers with a one-cycle result strobe.
interface sme_host_if;
    logic [7:0] chardata;
    logic       isstring;
    logic       ispattern;
    logic       valid;
    logic       match;
    logic [4:0] match_index;

    modport master (
        output chardata,
        output isstring,
        output ispattern,
        input  valid,
        input  match,
        input  match_index
    );

    modport slave (
        input  chardata,
        input  isstring,
        input  ispattern,
        output valid,
        output match,
        output match_index
    );
endinterface

// File: rtl/sme_host.sv
// SME host driver: walks a job list in a synchronous ROM, buffers string/pattern records,
// streams them to the string-match engine and stores each result in a result RAM.
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_IDLE     | after reset, waiting for start
// S_RD_HDR   | header byte read strobe issued
// S_DEC_HDR  | header byte on rom_data, decoded this cycle
// S_LD_STR   | streaming string payload from ROM into sbuf
// S_LD_PAT   | streaming pattern payload from ROM into pbuf
// S_SEND_STR | isstring burst of slen chars
// S_SEND_PAT | ispattern burst of plen chars, then strobes drop
// S_WAIT_V   | waiting for the engine result, timeout down-counter running
// S_WR_RES   | result RAM write strobe for one cycle
// S_DONE     | end record reached; done held until next start
// S_ERR      | bad header or timeout; err held until next start
module sme_host #(
    parameter int ROM_AW  = 10,
    parameter int RES_AW  = 6,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              rom_rd,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    sme_host_if.master        sme,
    output logic              res_we,
    output logic [RES_AW-1:0] res_addr,
    output logic [5:0]        res_data
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_HDR,
        S_DEC_HDR,
        S_LD_STR,
        S_LD_PAT,
        S_SEND_STR,
        S_SEND_PAT,
        S_WAIT_V,
        S_WR_RES,
        S_DONE,
        S_ERR
    } state_t;

    state_t          state;
    logic [7:0]      sbuf [32];
    logic [7:0]      pbuf [8];
    logic [5:0]      slen;
    logic [5:0]      plen;
    logic [5:0]      iss_cnt;   // payload reads still to issue after the current one
    logic [5:0]      ld_idx;    // next buffer slot to fill
    logic [5:0]      ld_last;   // index of the final payload byte
    logic [5:0]      snd_idx;
    logic            rd_q;      // rom_data carries a byte requested last cycle
    logic            str_loaded;
    logic            str_new;
    logic [TW-1:0]   tmr;
    logic [1:0]      hdr_type;
    logic [5:0]      hdr_len;
    logic            hdr_bad;

    assign hdr_type = rom_data[7:6];
    assign hdr_len  = rom_data[5:0];

    // Header legality: length range per record type, and a pattern needs a string first.
    always_comb begin
        hdr_bad = 1'b0;
        case (hdr_type)
            2'b00:   hdr_bad = (hdr_len == 6'd0) || (hdr_len > 6'd32);
            2'b01:   hdr_bad = !str_loaded || (hdr_len == 6'd0) || (hdr_len > 6'd8);
            2'b11:   hdr_bad = 1'b0;
            default: hdr_bad = 1'b1;
        endcase
    end

    // Payload buffers; contents only matter once loaded, so they carry no reset.
    always_ff @(posedge clk) begin
        if (rd_q && state == S_LD_STR) sbuf[ld_idx[4:0]] <= rom_data;
        if (rd_q && state == S_LD_PAT) pbuf[ld_idx[2:0]] <= rom_data;
    end

    // Main sequencer with registered outputs; reset drops the strobes immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            rom_rd        <= 1'b0;
            rom_addr      <= '0;
            res_we        <= 1'b0;
            res_addr      <= '0;
            res_data      <= '0;
            sme.chardata  <= 8'h00;
            sme.isstring  <= 1'b0;
            sme.ispattern <= 1'b0;
            slen          <= '0;
            plen          <= '0;
            iss_cnt       <= '0;
            ld_idx        <= '0;
            ld_last       <= '0;
            snd_idx       <= '0;
            rd_q          <= 1'b0;
            str_loaded    <= 1'b0;
            str_new       <= 1'b0;
            tmr           <= '0;
        end else begin
            rd_q <= rom_rd;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        err        <= 1'b0;
                        rom_addr   <= '0;
                        res_addr   <= '0;
                        str_loaded <= 1'b0;
                        str_new    <= 1'b0;
                        rom_rd     <= 1'b1;
                        state      <= S_RD_HDR;
                    end
                end
                S_RD_HDR: begin
                    rom_rd   <= 1'b0;
                    rom_addr <= rom_addr + 1'b1;
                    state    <= S_DEC_HDR;
                end
                S_DEC_HDR: begin
                    if (hdr_bad) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_ERR;
                    end else begin
                        case (hdr_type)
                            2'b00: begin
                                slen    <= hdr_len;
                                ld_last <= hdr_len - 6'd1;
                                iss_cnt <= hdr_len - 6'd1;
                                ld_idx  <= '0;
                                rom_rd  <= 1'b1;
                                state   <= S_LD_STR;
                            end
                            2'b01: begin
                                plen    <= hdr_len;
                                ld_last <= hdr_len - 6'd1;
                                iss_cnt <= hdr_len - 6'd1;
                                ld_idx  <= '0;
                                rom_rd  <= 1'b1;
                                state   <= S_LD_PAT;
                            end
                            default: begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= S_DONE;
                            end
                        endcase
                    end
                end
                S_LD_STR, S_LD_PAT: begin
                    if (rom_rd) begin
                        rom_addr <= rom_addr + 1'b1;
                        if (iss_cnt == 6'd0) rom_rd <= 1'b0;
                        else                 iss_cnt <= iss_cnt - 6'd1;
                    end
                    if (rd_q) begin
                        ld_idx <= ld_idx + 6'd1;
                        if (ld_idx == ld_last) begin
                            snd_idx <= '0;
                            if (state == S_LD_STR) begin
                                str_loaded <= 1'b1;
                                str_new    <= 1'b1;
                                rom_rd     <= 1'b1;
                                state      <= S_RD_HDR;
                            end else begin
                                state <= str_new ? S_SEND_STR : S_SEND_PAT;
                            end
                        end
                    end
                end
                S_SEND_STR: begin
                    sme.isstring  <= 1'b1;
                    sme.ispattern <= 1'b0;
                    sme.chardata  <= sbuf[snd_idx[4:0]];
                    str_new       <= 1'b0;
                    if (snd_idx == slen - 6'd1) begin
                        snd_idx <= '0;
                        state   <= S_SEND_PAT;
                    end else begin
                        snd_idx <= snd_idx + 6'd1;
                    end
                end
                S_SEND_PAT: begin
                    // The string burst hands over to the pattern burst with no idle cycle.
                    if (snd_idx == plen) begin
                        sme.isstring  <= 1'b0;
                        sme.ispattern <= 1'b0;
                        sme.chardata  <= 8'h00;
                        tmr           <= TW'(TIMEOUT - 1);
                        state         <= S_WAIT_V;
                    end else begin
                        sme.isstring  <= 1'b0;
                        sme.ispattern <= 1'b1;
                        sme.chardata  <= pbuf[snd_idx[2:0]];
                        snd_idx       <= snd_idx + 6'd1;
                    end
                end
                S_WAIT_V: begin
                    if (sme.valid) begin
                        res_data <= {sme.match, sme.match_index};
                        res_we   <= 1'b1;
                        state    <= S_WR_RES;
                    end else if (tmr == '0) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_ERR;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                S_WR_RES: begin
                    res_we   <= 1'b0;
                    res_addr <= res_addr + 1'b1;
                    rom_rd   <= 1'b1;
                    state    <= S_RD_HDR;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sme_host.sv
// Bench for sme_host: ROM model, SME responder and scoreboard queues of expected bursts/results.
module tb_sme_host;
    localparam int TIMEOUT = 1023;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       busy, done, err, rom_rd, res_we;
    logic [9:0] rom_addr;
    logic [7:0] rom_data;
    logic [5:0] res_addr, res_data;

    sme_host_if sif();

    sme_host #(.ROM_AW(10), .RES_AW(6), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .start(start),
        .busy(busy), .done(done), .err(err),
        .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_data(rom_data),
        .sme(sif),
        .res_we(res_we), .res_addr(res_addr), .res_data(res_data)
    );

    always #5 clk = ~clk;

    // Synchronous job ROM, one cycle read latency.
    logic [7:0] rom_mem [1024];
    always @(posedge clk) if (rom_rd) rom_data <= rom_mem[rom_addr];

    int checks = 0;
    int failures = 0;

    // Scoreboard: filled while the ROM image is built, observations collected while running.
    string      exp_burst_q[$];
    string      obs_burst_q[$];
    logic [11:0] exp_res_q[$];
    logic [11:0] obs_res_q[$];
    logic [5:0] resp_q[$];

    int    rom_ptr, res_idx;
    string cur_str;
    bit    str_pending;

    bit    prev_s, prev_p, resp_en, spur_en;
    string cur_s, cur_p;
    int    overlap_cnt, idle_nz_cnt, gap_bad_cnt, resp_wait, last_pat_fall;
    logic  first_rd;
    logic [9:0] first_addr;

    function automatic logic [5:0] sme_ref(input string s, input string p);
        for (int i = 0; i + p.len() <= s.len(); i++)
            if (s.substr(i, i + p.len() - 1) == p) return {1'b1, 5'(i)};
        return 6'd0;
    endfunction

    task automatic rom_clear();
        for (int i = 0; i < 1024; i++) rom_mem[i] = 8'hC0;
        rom_ptr = 0;
        res_idx = 0;
        str_pending = 0;
        exp_burst_q.delete();
        exp_res_q.delete();
        resp_q.delete();
    endtask

    task automatic add_byte(input logic [7:0] b);
        rom_mem[rom_ptr] = b;
        rom_ptr++;
    endtask

    task automatic add_str(input string s);
        add_byte({2'b00, 6'(s.len())});
        for (int i = 0; i < s.len(); i++) add_byte(s[i]);
        cur_str = s;
        str_pending = 1;
    endtask

    task automatic add_pat(input string p);
        logic [5:0] r;
        add_byte({2'b01, 6'(p.len())});
        for (int i = 0; i < p.len(); i++) add_byte(p[i]);
        if (str_pending) exp_burst_q.push_back({"S:", cur_str});
        str_pending = 0;
        exp_burst_q.push_back({"P:", p});
        r = sme_ref(cur_str, p);
        resp_q.push_back(r);
        exp_res_q.push_back({6'(res_idx), r});
        res_idx++;
    endtask

    // One negedge worth of observation plus the SME responder; records only.
    task automatic sample_cycle(input int cyc);
        logic [5:0] r;
        if (sif.valid) sif.valid = 1'b0;
        if (cyc == 1) begin
            first_rd = rom_rd;
            first_addr = rom_addr;
        end
        if (sif.isstring && sif.ispattern) overlap_cnt++;
        if (!sif.isstring && !sif.ispattern && sif.chardata != 8'h00) idle_nz_cnt++;
        if (resp_wait > 0) begin
            resp_wait--;
            if (resp_wait == 0) begin
                r = (resp_q.size() > 0) ? resp_q.pop_front() : 6'd0;
                sif.valid = 1'b1;
                sif.match = r[5];
                sif.match_index = r[4:0];
            end
        end
        if (sif.isstring) begin
            if (!prev_s) begin
                cur_s = "S:";
                if (spur_en) begin
                    sif.valid = 1'b1;
                    sif.match = 1'b1;
                    sif.match_index = 5'h1f;
                end
            end
            cur_s = $sformatf("%s%c", cur_s, sif.chardata);
        end else if (prev_s) begin
            obs_burst_q.push_back(cur_s);
            if (!sif.ispattern) gap_bad_cnt++;
        end
        if (sif.ispattern) begin
            if (!prev_p) cur_p = "P:";
            cur_p = $sformatf("%s%c", cur_p, sif.chardata);
        end else if (prev_p) begin
            obs_burst_q.push_back(cur_p);
            last_pat_fall = cyc;
            if (resp_en) resp_wait = 3;
        end
        if (res_we) obs_res_q.push_back({res_addr, res_data});
        prev_s = sif.isstring;
        prev_p = sif.ispattern;
    endtask

    task automatic run_job(input int budget, input int extra_start, output bit to, output int end_cyc);
        obs_burst_q.delete();
        obs_res_q.delete();
        overlap_cnt = 0; idle_nz_cnt = 0; gap_bad_cnt = 0;
        resp_wait = 0; last_pat_fall = 0; prev_s = 0; prev_p = 0;
        first_rd = 1'b0; first_addr = '1;
        sif.valid = 1'b0;
        to = 1; end_cyc = budget;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            start = (c == 0) || (extra_start != 0 && c == extra_start);
            sample_cycle(c);
            if (c >= 2 && (done || err)) begin
                to = 0;
                end_cyc = c;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, err, rom_rd, res_we} !== 5'b0)
            $display("FAIL reset_flags: got %b expected 00000", {busy, done, err, rom_rd, res_we});
        checks++;
        if (rom_addr !== 10'd0) $display("FAIL reset_rom_addr: got %0d expected 0", rom_addr);
        checks++;
        if (res_addr !== 6'd0) $display("FAIL reset_res_addr: got %0d expected 0", res_addr);
        checks++;
        if (res_data !== 6'd0) $display("FAIL reset_res_data: got %0d expected 0", res_data);
        checks++;
        if ({sif.isstring, sif.ispattern} !== 2'b00)
            $display("FAIL reset_strobes: got %b expected 00", {sif.isstring, sif.ispattern});
        checks++;
        if (sif.chardata !== 8'h00) $display("FAIL reset_chardata: got %h expected 00", sif.chardata);
        failures += ({busy, done, err, rom_rd, res_we} !== 5'b0) + (rom_addr !== 10'd0)
                  + (res_addr !== 6'd0) + (res_data !== 6'd0)
                  + ({sif.isstring, sif.ispattern} !== 2'b00) + (sif.chardata !== 8'h00);
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_jobs();
        bit to;
        int ec, n;
        for (int sc = 0; sc < 4; sc++) begin
            rom_clear();
            spur_en = 0;
            case (sc)
                0: begin add_str("abc"); add_pat("bc"); end
                1: begin add_str("hello world"); add_pat("world"); add_pat("lo"); add_pat("xyz"); spur_en = 1; end
                2: begin add_str("abcdefgh"); add_pat("def"); add_str("zq"); add_pat("q"); end
                default: begin
                    add_str("ABCDEFGHIJKLMNOPQRSTUVWXYZ012345"); add_pat("YZ012345");
                    add_str("x"); add_pat("x");
                end
            endcase
            add_byte(8'hC0);
            resp_en = 1;
            run_job(5000, (sc == 1) ? 12 : 0, to, ec);
            checks++;
            if (to) begin failures++; $display("FAIL jobs%0d_timeout: no done/err within budget", sc); end
            checks++;
            if ({done, busy, err} !== 3'b100) begin
                failures++; $display("FAIL jobs%0d_status: got done/busy/err=%b expected 100", sc, {done, busy, err});
            end
            checks++;
            if (obs_burst_q.size() != exp_burst_q.size()) begin
                failures++;
                $display("FAIL jobs%0d_burst_count: got %0d expected %0d", sc, obs_burst_q.size(), exp_burst_q.size());
            end
            n = (obs_burst_q.size() < exp_burst_q.size()) ? obs_burst_q.size() : exp_burst_q.size();
            for (int i = 0; i < n; i++) begin
                checks++;
                if (obs_burst_q[i] != exp_burst_q[i]) begin
                    failures++;
                    $display("FAIL jobs%0d_burst%0d: got %s expected %s", sc, i, obs_burst_q[i], exp_burst_q[i]);
                end
            end
            checks++;
            if (obs_res_q.size() != exp_res_q.size()) begin
                failures++;
                $display("FAIL jobs%0d_res_count: got %0d expected %0d", sc, obs_res_q.size(), exp_res_q.size());
            end
            n = (obs_res_q.size() < exp_res_q.size()) ? obs_res_q.size() : exp_res_q.size();
            for (int i = 0; i < n; i++) begin
                checks++;
                if (obs_res_q[i] !== exp_res_q[i]) begin
                    failures++;
                    $display("FAIL jobs%0d_result%0d: got addr=%0d data=%b expected addr=%0d data=%b", sc, i,
                             obs_res_q[i][11:6], obs_res_q[i][5:0], exp_res_q[i][11:6], exp_res_q[i][5:0]);
                end
            end
            checks++;
            if (overlap_cnt != 0 || gap_bad_cnt != 0 || idle_nz_cnt != 0) begin
                failures++;
                $display("FAIL jobs%0d_strobes: got overlap=%0d gap=%0d idle_char=%0d expected 0/0/0",
                         sc, overlap_cnt, gap_bad_cnt, idle_nz_cnt);
            end
        end
    endtask

    task automatic test_bad_headers();
        bit to;
        int ec;
        for (int bc = 0; bc < 6; bc++) begin
            rom_clear();
            case (bc)
                0: add_byte(8'h00);
                1: add_byte(8'h21);
                2: begin add_str("abc"); add_byte(8'h49); end
                3: add_byte(8'h80);
                4: begin add_byte(8'h42); add_byte("b"); add_byte("c"); end
                default: begin add_str("a"); add_byte(8'h40); end
            endcase
            resp_en = 1;
            run_job(500, 0, to, ec);
            checks++;
            if (to) begin failures++; $display("FAIL bad%0d_timeout: no done/err within budget", bc); end
            checks++;
            if ({done, busy, err} !== 3'b001) begin
                failures++; $display("FAIL bad%0d_status: got done/busy/err=%b expected 001", bc, {done, busy, err});
            end
            checks++;
            if (obs_res_q.size() != 0 || obs_burst_q.size() != 0) begin
                failures++;
                $display("FAIL bad%0d_activity: got res_we=%0d bursts=%0d expected 0/0", bc, obs_res_q.size(), obs_burst_q.size());
            end
        end
    endtask

    task automatic test_timeout();
        bit to;
        int ec;
        rom_clear();
        add_str("abc"); add_pat("a"); add_byte(8'hC0);
        resp_en = 0;
        run_job(3000, 0, to, ec);
        checks++;
        if (to) begin failures++; $display("FAIL tmo_bound: no err within budget"); end
        checks++;
        if ({done, busy, err} !== 3'b001) begin
            failures++; $display("FAIL tmo_status: got done/busy/err=%b expected 001", {done, busy, err});
        end
        checks++;
        if (ec - last_pat_fall != TIMEOUT) begin
            failures++; $display("FAIL tmo_cycles: got %0d expected %0d", ec - last_pat_fall, TIMEOUT);
        end
        checks++;
        if (obs_res_q.size() != 0) begin failures++; $display("FAIL tmo_res_we: got %0d expected 0", obs_res_q.size()); end

        rom_clear();
        add_str("abc"); add_pat("bc"); add_byte(8'hC0);
        resp_en = 1;
        run_job(3000, 0, to, ec);
        checks++;
        if (first_rd !== 1'b1 || first_addr !== 10'd0) begin
            failures++; $display("FAIL restart_addr: got rd=%b addr=%0d expected rd=1 addr=0", first_rd, first_addr);
        end
        checks++;
        if ({done, busy, err} !== 3'b100 || to) begin
            failures++; $display("FAIL restart_status: got done/busy/err=%b expected 100", {done, busy, err});
        end
        checks++;
        if (obs_res_q.size() != 1 || obs_res_q[0] !== {6'd0, 6'b100001}) begin
            failures++;
            $display("FAIL restart_result: got count=%0d first=%h expected count=1 first=%h",
                     obs_res_q.size(), (obs_res_q.size() > 0) ? obs_res_q[0] : 12'h0, {6'd0, 6'b100001});
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        rom_clear();
        add_str("ABCDEFGHIJKLMNOPQRSTUVWXYZ012345"); add_pat("AB"); add_byte(8'hC0);
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            start = (c == 0);
            if (sif.isstring) seen++;
            if (seen == 4) break;
        end
        start = 1'b0;
        checks++;
        if (seen != 4) begin failures++; $display("FAIL mid_reach: got %0d string cycles expected 4", seen); end
        reset = 1'b0;
        #1;
        checks++;
        if ({sif.isstring, sif.ispattern, busy} !== 3'b000 || sif.chardata !== 8'h00) begin
            failures++;
            $display("FAIL mid_async: got str/pat/busy=%b char=%h expected 000 00",
                     {sif.isstring, sif.ispattern, busy}, sif.chardata);
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, err, rom_rd, res_we, sif.isstring} !== 6'b0 || rom_addr !== 10'd0) begin
            failures++;
            $display("FAIL mid_idle: got flags=%b rom_addr=%0d expected 000000 0",
                     {busy, done, err, rom_rd, res_we, sif.isstring}, rom_addr);
        end
    endtask

    initial begin
        start = 1'b0;
        sif.valid = 1'b0;
        sif.match = 1'b0;
        sif.match_index = 5'd0;
        resp_en = 1;
        spur_en = 0;
        rom_clear();
        test_reset();
        test_jobs();
        test_bad_headers();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
